// File: rtl/if_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter and its combinational picker.
// rr_next gives the wrap-around increment used to advance the priority pointer.
package if_arb_pkg;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} arb_state_e;

   localparam int DEF_N_REQ  = 32'sd9;
   localparam int DEF_DATA_W = 32'sd32;

   function automatic int rr_next(input int ptr, input int n);
      int nxt;
      if (ptr >= n - 32'sd1) begin
         nxt = 32'sd0;
      end else begin
         nxt = ptr + 32'sd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
// Purely combinational so other schedulers can reuse it with their own pointer.
module rr_pick
   import if_arb_pkg::*;
#(
   parameter int N = DEF_N_REQ,
   localparam int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] idx,
   output logic            any
);

   // Scan offsets 0..N-1 from ptr; the first hit wins and later hits are ignored.
   always_comb begin
      int cand;
      cand  = 32'sd0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) begin
            cand = cand - N;
         end else begin
            cand = cand;
         end
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = ID_W'(cand);
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/if_rr_arbiter.sv
// Round-robin arbiter funnelling N_REQ valid/ready requesters into one registered
// output slot; a drained slot reloads in the same cycle so throughput is one word per cycle.
module if_rr_arbiter
   import if_arb_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DATA_W = DEF_DATA_W,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_REQ-1:0]               req_valid,
   input  logic [N_REQ-1:0][DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]               req_ready,
   output logic                           out_valid,
   output logic [DATA_W-1:0]              out_data,
   output logic [ID_W-1:0]                out_id,
   input  logic                           out_ready,
   output logic                           busy
);

   arb_state_e         state_r;
   arb_state_e         state_nxt_s;
   logic [DATA_W-1:0]  out_data_r;
   logic [ID_W-1:0]    out_id_r;
   logic [ID_W-1:0]    ptr_r;
   logic [N_REQ-1:0]   pick_grant_s;
   logic [ID_W-1:0]    pick_idx_s;
   logic               pick_any_s;
   logic               load_s;
   logic               grant_s;

   rr_pick #(.N(N_REQ)) u_pick (
      .req   (req_valid),
      .ptr   (ptr_r),
      .grant (pick_grant_s),
      .idx   (pick_idx_s),
      .any   (pick_any_s)
   );

   // Handshake: the slot may accept a word when empty or draining this cycle.
   always_comb begin
      load_s  = (state_r == EMPTY) || out_ready;
      grant_s = load_s && pick_any_s && rst_n;
      if (grant_s) begin
         req_ready = pick_grant_s;
      end else begin
         req_ready = '0;
      end
   end

   // State register plus payload/pointer capture on every grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= EMPTY;
         out_data_r <= '0;
         out_id_r   <= '0;
         ptr_r      <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (grant_s) begin
            out_data_r <= req_data[pick_idx_s];
            out_id_r   <= pick_idx_s;
            ptr_r      <= ID_W'(rr_next(int'(pick_idx_s), N_REQ));
         end else begin
            out_data_r <= out_data_r;
            out_id_r   <= out_id_r;
            ptr_r      <= ptr_r;
         end
      end
   end

   // Next state: a stalled FULL slot stays FULL; otherwise the slot follows the grant.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         EMPTY:   state_nxt_s = grant_s ? FULL : EMPTY;
         FULL:    state_nxt_s = (!load_s || grant_s) ? FULL : EMPTY;
         default: state_nxt_s = EMPTY;
      endcase
   end

   // Output decode from the registered slot.
   always_comb begin
      out_valid = (state_r == FULL);
      busy      = (state_r == FULL);
      out_data  = out_data_r;
      out_id    = out_id_r;
   end

endmodule

// File: tb/tb_if_rr_arbiter.sv
// Directed self-checking bench for if_rr_arbiter (N_REQ=9, DATA_W=32).
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
module tb_if_rr_arbiter;

   localparam int N  = 9;
   localparam int DW = 32;
   localparam int IW = $clog2(N);

   logic                 clk;
   logic                 rst_n;
   logic [N-1:0]         req_valid;
   logic [N-1:0][DW-1:0] req_data;
   logic [N-1:0]         req_ready;
   logic                 out_valid;
   logic [DW-1:0]        out_data;
   logic [IW-1:0]        out_id;
   logic                 out_ready;
   logic                 busy;

   int checks;
   int errors;

   if_rr_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic check_slot(input string tag, input logic v, input int id, input logic [DW-1:0] d);
      check_eq({tag, "_valid"}, 64'(out_valid), 64'(v));
      check_eq({tag, "_busy"},  64'(busy),      64'(v));
      check_eq({tag, "_id"},    64'(out_id),    64'(id));
      check_eq({tag, "_data"},  64'(out_data),  64'(d));
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      out_ready = 1'b1;
      req_valid = '1;
      for (int i = 0; i < N; i++) req_data[i] = 32'(i * 17);
      req_data[5] = 32'h0000_00A5;

      // Reset state, with every requester asserting valid
      #12;
      check_slot("rst", 1'b0, 0, 32'h0);
      check_eq("rst_ready", 64'(req_ready), 64'h0);
      rst_n     = 1'b1;
      req_valid = '0;

      // Single requester 3
      nxt();
      req_valid = 9'h008;
      smp();
      check_eq("single_ready", 64'(req_ready), 64'h008);
      nxt();
      req_valid = '0;
      smp();
      check_slot("single", 1'b1, 3, 32'h33);
      check_eq("single_idle_ready", 64'(req_ready), 64'h0);

      // Drain with nothing pending; pointer must still be 4 afterwards
      nxt();
      req_valid = 9'h028;
      smp();
      check_eq("drain_valid", 64'(out_valid), 64'h0);
      check_eq("drain_ptr_ready", 64'(req_ready), 64'h020);
      nxt();
      req_valid = 9'h008;
      smp();
      check_slot("after_drain5", 1'b1, 5, 32'hA5);
      check_eq("same_idx_ready", 64'(req_ready), 64'h008);
      nxt();
      req_valid = '0;
      smp();
      check_slot("same_idx", 1'b1, 3, 32'h33);

      // Full contention after reset: 0..8,0,1 with no bubbles
      nxt();
      pulse_reset();
      req_valid = '1;
      smp();
      check_eq("rr_ready0", 64'(req_ready), 64'h001);
      for (int k = 1; k <= 11; k++) begin
         nxt();
         smp();
         check_slot($sformatf("rr%0d", k - 1), 1'b1, (k - 1) % N, req_data[(k - 1) % N]);
         if (k < 11) check_eq($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(1 << (k % N)));
      end

      // Wrap: pointer at 8, requesters 8 and 1
      nxt();
      req_valid = '0;
      pulse_reset();
      req_valid = 9'h080;
      smp();
      check_eq("wrap_ready7", 64'(req_ready), 64'h080);
      nxt();
      req_valid = 9'h102;
      smp();
      check_slot("wrap7", 1'b1, 7, req_data[7]);
      check_eq("wrap_ready8", 64'(req_ready), 64'h100);
      nxt();
      smp();
      check_slot("wrap8", 1'b1, 8, req_data[8]);
      check_eq("wrap_ready1", 64'(req_ready), 64'h002);
      nxt();
      smp();
      check_slot("wrap1", 1'b1, 1, req_data[1]);
      check_eq("wrap_ready8b", 64'(req_ready), 64'h100);
      nxt();
      req_valid = '0;
      smp();
      check_slot("wrap8b", 1'b1, 8, req_data[8]);

      // Stall: word from 5 held three cycles, requester 2 waiting
      nxt();
      req_valid = 9'h020;
      smp();
      check_eq("stall_ready5", 64'(req_ready), 64'h020);
      nxt();
      req_valid = 9'h004;
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         smp();
         check_slot($sformatf("stall%0d", s), 1'b1, 5, 32'hA5);
         check_eq($sformatf("stall_ready%0d", s), 64'(req_ready), 64'h0);
         nxt();
         if (s == 2) out_ready = 1'b1;
      end
      smp();
      check_slot("release", 1'b1, 5, 32'hA5);
      check_eq("release_ready2", 64'(req_ready), 64'h004);
      nxt();
      req_valid = '0;
      smp();
      check_slot("after_stall", 1'b1, 2, req_data[2]);

      // Asynchronous reset while holding a word from requester 6
      nxt();
      req_valid = 9'h040;
      smp();
      check_eq("pre_rst_ready6", 64'(req_ready), 64'h040);
      nxt();
      req_valid = 9'h084;
      out_ready = 1'b0;
      smp();
      check_slot("full6", 1'b1, 6, req_data[6]);
      #2;
      rst_n = 1'b0;
      #1;
      check_slot("async_rst", 1'b0, 0, 32'h0);
      check_eq("async_rst_ready", 64'(req_ready), 64'h0);
      #1;
      rst_n = 1'b1;
      smp();
      check_slot("post_rst", 1'b1, 2, req_data[2]);
      check_eq("post_rst_stall_ready", 64'(req_ready), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
